// File: rtl/tlm_target_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tlm_target_mem_if
// Brief    : Request/response channel bundle for the TLM target memory.
// Revision : 1.0
// ============================================================================
interface tlm_target_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_cmd;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_data;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic [1:0]            rsp_status;

  modport master (
    output req_valid, req_cmd, req_addr, req_data, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface
`default_nettype wire

// File: rtl/tlm_target_mem.sv
`default_nettype none
// ============================================================================
// Module   : tlm_target_mem
// Brief    : TLM generic-payload target memory, one request at a time.
// Revision : 1.0
// ============================================================================
module tlm_target_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  tlm_target_mem_if.slave   bus,
  output logic              end_sim_o,
  output logic [31:0]       txn_count_o
);

  localparam int c_NBE   = DATA_W / 8;
  localparam int c_BSEL  = $clog2(c_NBE);
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_INIT =
    c_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic c_SKIP_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] c_CMD_READ    = 2'd0;
  localparam logic [1:0] c_CMD_WRITE   = 2'd1;
  localparam logic [1:0] c_CMD_END_SIM = 2'd3;

  localparam logic [1:0] c_RSP_OK       = 2'd0;
  localparam logic [1:0] c_RSP_ADDR_ERR = 2'd1;
  localparam logic [1:0] c_RSP_BE_ERR   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_cmd;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_CNT_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]    r_rsp_data;
  logic [1:0]           r_rsp_status;
  logic [31:0]          r_txn_count;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_req_ready;
  logic                 w_rsp_valid;
  logic                 w_end_sim;
  logic                 w_accept;
  logic                 w_handshake;
  logic                 w_misaligned;
  logic [ADDR_W-1:0]    w_word;
  logic                 w_in_range;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_is_rw;
  logic                 w_addr_err;
  logic                 w_be_err;
  logic [1:0]           w_status;
  logic                 w_wr_en;
  logic                 w_rsp_load;
  logic [1:0]           w_load_cmd;
  logic [1:0]           w_load_status;
  logic [c_IDX_W-1:0]   w_load_idx;
  logic [DATA_W-1:0]    w_rsp_data_nxt;

  // Sub-word address bits exist only when a word holds more than one byte.
  generate
    if (c_BSEL > 0) begin : g_align_chk
      assign w_misaligned = |bus.req_addr[c_BSEL-1:0];
    end else begin : g_align_none
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_word     = bus.req_addr >> c_BSEL;
  assign w_in_range = (w_word < ADDR_W'(DEPTH));
  assign w_idx      = w_word[c_IDX_W-1:0];
  assign w_is_rw    = (bus.req_cmd == c_CMD_READ) || (bus.req_cmd == c_CMD_WRITE);
  assign w_addr_err = w_is_rw && (w_misaligned || !w_in_range);
  assign w_be_err   = (bus.req_cmd == c_CMD_READ) && (bus.req_be == '0);
  assign w_status   = w_addr_err ? c_RSP_ADDR_ERR :
                      w_be_err   ? c_RSP_BE_ERR   : c_RSP_OK;

  assign w_wr_en = rst_ni && w_accept && (bus.req_cmd == c_CMD_WRITE) && !w_addr_err;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_end_sim   = 1'b0;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = c_SKIP_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = (r_cmd == c_CMD_END_SIM) ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        w_end_sim = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // With no wait cycles RESP is entered straight from IDLE, so the response
  // word comes from the live request instead of the latched copy.
  assign w_rsp_load     = (r_state != S_RESP) && (w_state_nxt == S_RESP);
  assign w_load_cmd     = (r_state == S_IDLE) ? bus.req_cmd : r_cmd;
  assign w_load_status  = (r_state == S_IDLE) ? w_status    : r_rsp_status;
  assign w_load_idx     = (r_state == S_IDLE) ? w_idx       : r_idx;
  assign w_rsp_data_nxt = ((w_load_cmd == c_CMD_READ) && (w_load_status == c_RSP_OK)) ?
                          r_mem[w_load_idx] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd        <= c_CMD_READ;
      r_idx        <= '0;
      r_wait_cnt   <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= c_RSP_OK;
      r_txn_count  <= '0;
    end else begin
      if (w_accept) begin
        r_cmd        <= bus.req_cmd;
        r_idx        <= w_idx;
        r_rsp_status <= w_status;
        r_wait_cnt   <= c_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_rsp_data_nxt;
      end
      if (w_handshake) begin
        r_txn_count <= r_txn_count + 32'd1;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < c_NBE; k++) begin
        if (bus.req_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= bus.req_data[8*k +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_status = r_rsp_status;
  assign end_sim_o      = w_end_sim;
  assign txn_count_o    = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_tlm_target_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlm_target_mem
// Brief    : Self-checking bench for three tlm_target_mem configurations.
// Revision : 1.0
// ============================================================================
module tb_tlm_target_mem;

  localparam logic [1:0] READ = 2'd0, WRITE = 2'd1, IGNORE = 2'd2, END_SIM = 2'd3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Configuration table: A = 32b/256/W1, B = 32b/256/W0, C = 64b/100/W3.
  int c_w[3]     = '{1, 0, 3};
  int c_depth[3] = '{256, 256, 100};
  int c_nb[3]    = '{4, 4, 8};

  logic [7:0]  mbyte [longint];
  int          mtxn [3];

  logic        end_sim_a, end_sim_b, end_sim_c;
  logic [31:0] txn_a, txn_b, txn_c;

  tlm_target_mem_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  tlm_target_mem_if #(.DATA_W(32), .ADDR_W(32)) if_b ();
  tlm_target_mem_if #(.DATA_W(64), .ADDR_W(32)) if_c ();

  tlm_target_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave), .end_sim_o(end_sim_a), .txn_count_o(txn_a));
  tlm_target_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave), .end_sim_o(end_sim_b), .txn_count_o(txn_b));
  tlm_target_mem #(.DATA_W(64), .ADDR_W(32), .DEPTH(100), .WAIT_CYCLES(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_c.slave), .end_sim_o(end_sim_c), .txn_count_o(txn_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic [1:0] cmd,
                         input logic [31:0] addr, input logic [63:0] data, input logic [7:0] be);
    case (sel)
      0: begin
        if_a.req_valid = v; if_a.req_cmd = cmd; if_a.req_addr = addr;
        if_a.req_data = data[31:0]; if_a.req_be = be[3:0];
      end
      1: begin
        if_b.req_valid = v; if_b.req_cmd = cmd; if_b.req_addr = addr;
        if_b.req_data = data[31:0]; if_b.req_be = be[3:0];
      end
      default: begin
        if_c.req_valid = v; if_c.req_cmd = cmd; if_c.req_addr = addr;
        if_c.req_data = data; if_c.req_be = be;
      end
    endcase
  endtask

  task automatic set_rsp_ready(input int sel, input logic v);
    case (sel)
      0:       if_a.rsp_ready = v;
      1:       if_b.rsp_ready = v;
      default: if_c.rsp_ready = v;
    endcase
  endtask

  task automatic peek(input int sel, output logic rr, output logic rv, output logic [1:0] st,
                      output logic [63:0] d, output logic es, output logic [31:0] tc);
    case (sel)
      0: begin
        rr = if_a.req_ready; rv = if_a.rsp_valid; st = if_a.rsp_status;
        d = {32'd0, if_a.rsp_data}; es = end_sim_a; tc = txn_a;
      end
      1: begin
        rr = if_b.req_ready; rv = if_b.rsp_valid; st = if_b.rsp_status;
        d = {32'd0, if_b.rsp_data}; es = end_sim_b; tc = txn_b;
      end
      default: begin
        rr = if_c.req_ready; rv = if_c.rsp_valid; st = if_c.rsp_status;
        d = if_c.rsp_data; es = end_sim_c; tc = txn_c;
      end
    endcase
  endtask

  // Byte-addressed reference memory; applies accepted writes and predicts the response.
  task automatic model(input int sel, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [7:0] be,
                       output logic [1:0] e_st, output logic [63:0] e_d, output bit known);
    longint unsigned a    = longint'(addr);
    longint          base = longint'(sel) << 40;
    int              nb   = c_nb[sel];
    logic [7:0]      bmask = (nb == 8) ? 8'hFF : 8'h0F;
    e_st  = 2'd0;
    e_d   = 64'd0;
    known = 1'b1;
    if (cmd == READ || cmd == WRITE) begin
      if ((a % nb) != 0 || (a / nb) >= longint'(c_depth[sel])) e_st = 2'd1;
      else if (cmd == READ && (be & bmask) == 8'd0)            e_st = 2'd3;
    end
    if (cmd == WRITE && e_st == 2'd0) begin
      for (int k = 0; k < nb; k++)
        if (be[k]) mbyte[base + longint'(a) + k] = data[8*k +: 8];
    end
    if (cmd == READ && e_st == 2'd0) begin
      for (int k = 0; k < nb; k++) begin
        if (mbyte.exists(base + longint'(a) + k)) e_d[8*k +: 8] = mbyte[base + longint'(a) + k];
        else known = 1'b0;
      end
    end
  endtask

  task automatic do_txn(input int sel, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] data, input logic [7:0] be, input int hold,
                        output logic [1:0] o_st, output logic [63:0] o_d);
    logic rr, rv, es;
    logic [1:0] st, e_st;
    logic [63:0] d, e_d;
    logic [31:0] tc;
    bit known;
    int cyc, lat;
    model(sel, cmd, addr, data, be, e_st, e_d, known);
    @(negedge clk);
    set_req(sel, 1'b1, cmd, addr, data, be);
    set_rsp_ready(sel, hold == 0);
    cyc = 0;
    peek(sel, rr, rv, st, d, es, tc);
    while (!rr && cyc < 20) begin
      @(negedge clk); cyc++; peek(sel, rr, rv, st, d, es, tc);
    end
    chk("accept_in_time", 64'(cyc < 20), 64'd1);
    @(negedge clk);
    set_req(sel, 1'b0, READ, 32'd0, 64'd0, 8'd0);
    lat = 1;
    peek(sel, rr, rv, st, d, es, tc);
    chk("busy_after_accept", 64'(rr), 64'd0);
    while (!rv && lat < 20) begin
      @(negedge clk); lat++; peek(sel, rr, rv, st, d, es, tc);
    end
    chk("latency", 64'(lat), 64'(c_w[sel] + 1));
    chk("status", 64'(st), 64'(e_st));
    if (known) chk("data", d, e_d);
    o_st = st;
    o_d  = d;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      peek(sel, rr, rv, st, d, es, tc);
      chk("stall_valid", 64'(rv), 64'd1);
      chk("stall_req_ready", 64'(rr), 64'd0);
      chk("stall_status", 64'(st), 64'(e_st));
      if (known) chk("stall_data", d, e_d);
    end
    set_rsp_ready(sel, 1'b1);
    @(negedge clk);
    set_rsp_ready(sel, 1'b0);
    mtxn[sel]++;
    peek(sel, rr, rv, st, d, es, tc);
    chk("valid_after_hs", 64'(rv), 64'd0);
    chk("ready_after_hs", 64'(rr), 64'(cmd != END_SIM));
    chk("end_sim_after_hs", 64'(es), 64'(cmd == END_SIM));
    chk("txn_count", 64'(tc), 64'(mtxn[sel]));
  endtask

  initial begin
    logic rr, rv, es;
    logic [1:0] st;
    logic [63:0] d;
    logic [31:0] tc, addr;
    logic [1:0] cmd;
    int sel, idx;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_req(s, 1'b0, READ, 32'd0, 64'd0, 8'd0);
      set_rsp_ready(s, 1'b0);
      mtxn[s] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      peek(s, rr, rv, st, d, es, tc);
      chk("rst_req_ready", 64'(rr), 64'd1);
      chk("rst_rsp_valid", 64'(rv), 64'd0);
      chk("rst_rsp_data", d, 64'd0);
      chk("rst_rsp_status", 64'(st), 64'd0);
      chk("rst_end_sim", 64'(es), 64'd0);
      chk("rst_txn_count", 64'(tc), 64'd0);
    end

    // Directed: full write/read, byte-enable merge, error cases on A.
    do_txn(0, WRITE, 32'h10, 64'hDEADBEEF, 8'hF, 0, st, d);
    do_txn(0, READ,  32'h10, 64'd0, 8'hF, 0, st, d);
    chk("plan_read_deadbeef", d, 64'hDEADBEEF);
    do_txn(0, WRITE, 32'h10, 64'h11223344, 8'h5, 0, st, d);
    do_txn(0, READ,  32'h10, 64'd0, 8'hF, 0, st, d);
    chk("plan_byte_merge", d, 64'hDE22BE44);
    do_txn(0, READ,  32'h400, 64'd0, 8'hF, 0, st, d);
    chk("plan_oob_status", 64'(st), 64'd1);
    do_txn(0, WRITE, 32'h13, 64'h55555555, 8'hF, 0, st, d);
    chk("plan_misalign_status", 64'(st), 64'd1);
    do_txn(0, READ,  32'h10, 64'd0, 8'h0, 0, st, d);
    chk("plan_be_zero_status", 64'(st), 64'd3);
    do_txn(0, WRITE, 32'h10, 64'h99999999, 8'h0, 0, st, d);
    do_txn(0, IGNORE, 32'h10, 64'h12345678, 8'hF, 0, st, d);
    do_txn(0, READ,  32'h10, 64'd0, 8'h1, 5, st, d);
    chk("plan_word_kept", d, 64'hDE22BE44);

    // W=0 configuration, with backpressure.
    do_txn(1, WRITE, 32'h3FC, 64'hA5A5_0F0F, 8'hF, 0, st, d);
    do_txn(1, READ,  32'h3FC, 64'd0, 8'hF, 5, st, d);
    do_txn(1, READ,  32'h400, 64'd0, 8'hF, 0, st, d);

    // 64-bit, DEPTH=100, W=3.
    do_txn(2, WRITE, 32'h318, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, st, d);
    chk("plan_idx99_ok", 64'(st), 64'd0);
    do_txn(2, WRITE, 32'h320, 64'h1, 8'hFF, 0, st, d);
    chk("plan_idx100_err", 64'(st), 64'd1);
    do_txn(2, READ,  32'h318, 64'd0, 8'h80, 2, st, d);
    chk("plan_idx99_data", d, 64'h0123_4567_89AB_CDEF);

    // Known contents for the first 16 words, then randomised traffic.
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++)
        do_txn(s, WRITE, 32'(w * c_nb[s]), {$urandom, $urandom}, 8'hFF, 0, st, d);
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 2);
      idx  = $urandom_range(0, 19);
      addr = (idx < 16) ? 32'(idx * c_nb[sel]) : 32'(c_depth[sel] * c_nb[sel] + idx);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, c_nb[sel] - 1));
      cmd  = 2'($urandom_range(0, 2));
      do_txn(sel, cmd, addr, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), st, d);
    end

    // END_SIM on A: further requests are ignored.
    do_txn(0, END_SIM, 32'h0, 64'h0, 8'h0, 0, st, d);
    chk("end_sim_status", 64'(st), 64'd0);
    @(negedge clk);
    set_req(0, 1'b1, READ, 32'h10, 64'd0, 8'hF);
    set_rsp_ready(0, 1'b1);
    repeat (4) @(negedge clk);
    peek(0, rr, rv, st, d, es, tc);
    chk("done_no_valid", 64'(rv), 64'd0);
    chk("done_req_ready", 64'(rr), 64'd0);
    chk("done_end_sim", 64'(es), 64'd1);
    chk("done_txn_hold", 64'(tc), 64'(mtxn[0]));
    set_req(0, 1'b0, READ, 32'd0, 64'd0, 8'd0);
    set_rsp_ready(0, 1'b0);

    // Reset while C sits in WAIT after accepting a write.
    begin
      logic [1:0] e_st;
      logic [63:0] e_d;
      bit known;
      model(2, WRITE, 32'h50, 64'hCAFE_F00D_1234_5678, 8'hFF, e_st, e_d, known);
    end
    @(negedge clk);
    set_req(2, 1'b1, WRITE, 32'h50, 64'hCAFE_F00D_1234_5678, 8'hFF);
    @(negedge clk);
    set_req(2, 1'b0, READ, 32'd0, 64'd0, 8'd0);
    peek(2, rr, rv, st, d, es, tc);
    chk("c_in_wait", 64'(rr), 64'd0);
    rst_n = 1'b0;
    #1;
    peek(2, rr, rv, st, d, es, tc);
    chk("midwait_rst_ready", 64'(rr), 64'd1);
    chk("midwait_rst_valid", 64'(rv), 64'd0);
    chk("midwait_rst_txn", 64'(tc), 64'd0);
    peek(0, rr, rv, st, d, es, tc);
    chk("a_rst_end_sim", 64'(es), 64'd0);
    chk("a_rst_ready", 64'(rr), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) mtxn[s] = 0;
    do_txn(2, READ, 32'h50, 64'd0, 8'hFF, 0, st, d);
    chk("write_survives_rst", d, 64'hCAFE_F00D_1234_5678);
    do_txn(0, READ, 32'h0, 64'd0, 8'hF, 0, st, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
